// File: rtl/ex_pkg.sv
// ex_pkg: shared encodings for the execute stage.
//   - ALU operation codes carried on id_aluc.
//   - Multiply/divide operation codes carried on id_md_op.
//   - Forwarding-source select used by the operand muxes.
package ex_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_SRA  = 4'd10;
  localparam logic [3:0] ALU_LUI  = 4'd11;

  // Codes 0 and 7 mean "no multiply/divide activity".
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MFHI  = 3'd5;
  localparam logic [2:0] MD_MFLO  = 3'd6;

  typedef enum logic [1:0] {
    FWD_ID,
    FWD_EXMEM,
    FWD_MEMWB
  } fwd_sel_e;

  // Operations that start the iterative unit.
  function automatic logic md_is_arith(input logic [2:0] op);
    return op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU};
  endfunction

  // Operations that touch HI/LO and so must wait for a running operation.
  function automatic logic md_uses_hilo(input logic [2:0] op);
    return op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MFHI, MD_MFLO};
  endfunction

endpackage

// File: rtl/ex_stage_fwd_md_md_unit.sv
// md_unit: iterative multiply/divide with HI/LO result registers.
//   clk, reset : clock, synchronous active-high reset (aborts a running op)
//   start      : accept op/a/b this cycle (ignored while busy)
//   op         : MULT, MULTU, DIV, DIVU (ex_pkg encoding)
//   a, b       : operands (a = multiplicand / dividend, b = multiplier / divisor)
//   busy       : high for exactly DW cycles after acceptance
//   hi, lo     : product {hi,lo}, or remainder (hi) and quotient (lo)
// Both algorithms work on magnitudes; signs are applied when the last
// iteration writes HI/LO.
module md_unit
  import ex_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [2:0]    op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic          busy,
  output logic [DW-1:0] hi,
  output logic [DW-1:0] lo
);

  localparam int CW = $clog2(DW);

  // acc: partial-product high half (mult) or partial remainder (div).
  // sh : multiplier being consumed (mult) or dividend shifting out / quotient
  //      shifting in (div).
  // opnd: multiplicand or divisor magnitude.
  logic [CW-1:0] cnt;
  logic [DW-1:0] acc, sh, opnd;
  logic          is_div, neg_q, neg_r, div_zero;

  logic          op_signed, a_neg, b_neg, op_div;
  logic [DW-1:0] a_mag, b_mag;

  logic [DW:0]   mul_sum, div_shift, div_diff;
  logic          div_ge;
  logic [DW-1:0] acc_nx, sh_nx;
  logic [2*DW-1:0] prod, prod_fix;
  logic [DW-1:0] hi_res, lo_res;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    op_signed = (op == MD_MULT) || (op == MD_DIV);
    op_div    = (op == MD_DIV)  || (op == MD_DIVU);
    a_neg     = op_signed && a[DW-1];
    b_neg     = op_signed && b[DW-1];
    a_mag     = a_neg ? -a : a;
    b_mag     = b_neg ? -b : b;
  end

  always_comb begin
    // Shift-add step: add the multiplicand when the current multiplier bit
    // is set, then shift the whole {acc,sh} pair right by one.
    mul_sum   = {1'b0, acc} + (sh[0] ? {1'b0, opnd} : '0);
    // Restoring step: bring the next dividend bit into the remainder and
    // subtract the divisor when it fits. A zero divisor always "fits", which
    // yields an all-ones quotient and leaves the dividend as remainder.
    div_shift = {acc, sh[DW-1]};
    div_diff  = div_shift - {1'b0, opnd};
    div_ge    = div_shift >= {1'b0, opnd};

    acc_nx = mul_sum[DW:1];
    sh_nx  = {mul_sum[0], sh[DW-1:1]};
    if (is_div) begin
      acc_nx = div_ge ? div_diff[DW-1:0] : div_shift[DW-1:0];
      sh_nx  = {sh[DW-2:0], div_ge};
    end

    prod     = {acc_nx, sh_nx};
    prod_fix = neg_q ? -prod : prod;

    hi_res = prod_fix[2*DW-1:DW];
    lo_res = prod_fix[DW-1:0];
    if (is_div) begin
      hi_res = neg_r ? -acc_nx : acc_nx;
      lo_res = div_zero ? '1 : (neg_q ? -sh_nx : sh_nx);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy     <= 1'b0;
      cnt      <= '0;
      acc      <= '0;
      sh       <= '0;
      opnd     <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else if (busy) begin
      acc <= acc_nx;
      sh  <= sh_nx;
      cnt <= cnt + CW'(1);
      if (cnt == CW'(DW - 1)) begin
        busy <= 1'b0;
        cnt  <= '0;
        hi   <= hi_res;
        lo   <= lo_res;
      end
    end else if (start) begin
      busy     <= 1'b1;
      cnt      <= '0;
      acc      <= '0;
      is_div   <= op_div;
      sh       <= op_div ? a_mag : b_mag;
      opnd     <= op_div ? b_mag : a_mag;
      neg_q    <= a_neg ^ b_neg;
      neg_r    <= a_neg;
      div_zero <= (b == '0);
    end
  end

endmodule

// File: rtl/ex_stage_fwd_md.sv
// ex_stage_fwd_md: pipelined execute stage with operand forwarding and an
// iterative multiply/divide unit.
//   clk, reset            : clock, synchronous active-high reset
//   id_*                  : ID/EX register contents (valid, controls, operands)
//   flush                 : kill the instruction in ID/EX this cycle
//   wb_wreg/waddr/wdata   : MEM/WB write port, used as forwarding source
//   ex_stall              : hold IF/ID and ID/EX while HI/LO are not ready
//   ex_valid, ex_*        : EX/MEM pipeline register outputs
//   md_busy               : multiply/divide unit is iterating
module ex_stage_fwd_md
  import ex_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          id_valid,
  input  logic          flush,
  input  logic [3:0]    id_aluc,
  input  logic [2:0]    id_md_op,
  input  logic          id_aluimm,
  input  logic          id_regrt,
  input  logic          id_wreg,
  input  logic          id_wmem,
  input  logic          id_mem2reg,
  input  logic [AW-1:0] id_rs_addr,
  input  logic [AW-1:0] id_rt_addr,
  input  logic [AW-1:0] id_rd_addr,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [DW-1:0] id_imm,
  input  logic          wb_wreg,
  input  logic [AW-1:0] wb_waddr,
  input  logic [DW-1:0] wb_wdata,
  output logic          ex_stall,
  output logic          ex_valid,
  output logic [DW-1:0] ex_alu_out,
  output logic [DW-1:0] ex_rt_data,
  output logic [AW-1:0] ex_waddr,
  output logic          ex_wreg,
  output logic          ex_wmem,
  output logic          ex_mem2reg,
  output logic          md_busy
);

  localparam int SW = $clog2(DW);

  fwd_sel_e      sel_rs, sel_rt;
  logic [DW-1:0] rs_fwd, rt_fwd, op_b, alu_res, result, md_hi, md_lo;
  logic [SW-1:0] shamt;
  logic [AW-1:0] dest;
  logic          exmem_fwd_ok, md_start, bubble;

  // A load in EX/MEM has no data yet; the ID hazard unit keeps its
  // consumers out, so it is simply not a forwarding source here.
  assign exmem_fwd_ok = ex_valid && ex_wreg && !ex_mem2reg;

  always_comb begin
    sel_rs = FWD_ID;
    sel_rt = FWD_ID;
    if (id_rs_addr != '0) begin
      if (exmem_fwd_ok && ex_waddr == id_rs_addr)    sel_rs = FWD_EXMEM;
      else if (wb_wreg && wb_waddr == id_rs_addr)    sel_rs = FWD_MEMWB;
    end
    if (id_rt_addr != '0) begin
      if (exmem_fwd_ok && ex_waddr == id_rt_addr)    sel_rt = FWD_EXMEM;
      else if (wb_wreg && wb_waddr == id_rt_addr)    sel_rt = FWD_MEMWB;
    end
  end

  always_comb begin
    case (sel_rs)
      FWD_EXMEM: rs_fwd = ex_alu_out;
      FWD_MEMWB: rs_fwd = wb_wdata;
      default:   rs_fwd = id_rs_data;
    endcase
    case (sel_rt)
      FWD_EXMEM: rt_fwd = ex_alu_out;
      FWD_MEMWB: rt_fwd = wb_wdata;
      default:   rt_fwd = id_rt_data;
    endcase
  end

  assign op_b  = id_aluimm ? id_imm : rt_fwd;
  assign shamt = op_b[SW-1:0];
  assign dest  = id_regrt ? id_rt_addr : id_rd_addr;

  always_comb begin
    alu_res = '0;
    case (id_aluc)
      ALU_ADD:  alu_res = rs_fwd + op_b;
      ALU_SUB:  alu_res = rs_fwd - op_b;
      ALU_AND:  alu_res = rs_fwd & op_b;
      ALU_OR:   alu_res = rs_fwd | op_b;
      ALU_XOR:  alu_res = rs_fwd ^ op_b;
      ALU_NOR:  alu_res = ~(rs_fwd | op_b);
      ALU_SLT:  alu_res = {{(DW-1){1'b0}}, ($signed(rs_fwd) < $signed(op_b))};
      ALU_SLTU: alu_res = {{(DW-1){1'b0}}, (rs_fwd < op_b)};
      ALU_SLL:  alu_res = rs_fwd << shamt;
      ALU_SRL:  alu_res = rs_fwd >> shamt;
      ALU_SRA:  alu_res = $signed(rs_fwd) >>> shamt;
      ALU_LUI:  alu_res = op_b << (DW / 2);
      default:  alu_res = '0;
    endcase
  end

  always_comb begin
    result = alu_res;
    if (id_md_op == MD_MFHI)      result = md_hi;
    else if (id_md_op == MD_MFLO) result = md_lo;
  end

  // A flush removes the waiting instruction, so it never needs to stall.
  assign ex_stall = id_valid && !flush && md_busy && md_uses_hilo(id_md_op);
  assign md_start = id_valid && !flush && !ex_stall && md_is_arith(id_md_op);
  assign bubble   = ex_stall || flush || !id_valid;

  md_unit #(.DW(DW)) u_md (
    .clk   (clk),
    .reset (reset),
    .start (md_start),
    .op    (id_md_op),
    .a     (rs_fwd),
    .b     (rt_fwd),
    .busy  (md_busy),
    .hi    (md_hi),
    .lo    (md_lo)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid   <= 1'b0;
      ex_alu_out <= '0;
      ex_rt_data <= '0;
      ex_waddr   <= '0;
      ex_wreg    <= 1'b0;
      ex_wmem    <= 1'b0;
      ex_mem2reg <= 1'b0;
    end else if (bubble) begin
      // Data fields are held; only the valid and control bits matter.
      ex_valid   <= 1'b0;
      ex_wreg    <= 1'b0;
      ex_wmem    <= 1'b0;
      ex_mem2reg <= 1'b0;
    end else begin
      ex_valid   <= 1'b1;
      ex_alu_out <= result;
      ex_rt_data <= rt_fwd;
      ex_waddr   <= dest;
      // Starting a multiply/divide writes HI/LO only, never the register file.
      ex_wreg    <= id_wreg && !md_is_arith(id_md_op);
      ex_wmem    <= id_wmem;
      ex_mem2reg <= id_mem2reg;
    end
  end

endmodule

// File: doc/ex_stage_fwd_md.md
Name: ex_stage_fwd_md

Overview:
- Parametrised successor of the single-cycle execute stage.
- Adds operand forwarding from EX/MEM and MEM/WB, pipeline valid/flush, and an iterative multiply/divide unit with HI/LO registers.
- Asserts a stall when the decode stage needs a result the multiply/divide unit has not produced yet.
- Sits between ID/EX and EX/MEM and drives the EX/MEM pipeline register.

Parameters:
- DW, 32, datapath width (≥8).
- AW, 5, register address width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- id_valid  in  1  ID/EX holds a real instruction
- flush  in  1  kill the instruction currently in ID/EX
- id_aluc  in  4  ALU op (package encoding)
- id_md_op  in  3  0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 none
- id_aluimm, id_regrt, id_wreg, id_wmem, id_mem2reg  in  1 each  control bits
- id_rs_addr, id_rt_addr, id_rd_addr  in  AW each  register addresses
- id_rs_data, id_rt_data, id_imm  in  DW each  operands
- wb_wreg  in  1  MEM/WB writes the register file
- wb_waddr  in  AW  MEM/WB destination address
- wb_wdata  in  DW  MEM/WB write data
- ex_stall  out  1  hold IF/ID and ID/EX
- ex_valid  out  1  EX/MEM valid
- ex_alu_out  out  DW  result
- ex_rt_data  out  DW  store data (forwarded)
- ex_waddr  out  AW  destination
- ex_wreg, ex_wmem, ex_mem2reg  out  1 each  control bits, gated by ex_valid
- md_busy  out  1  multiply/divide unit iterating

Behaviour:
- Reset: every output register, HI, LO and the iteration counter go to 0; md_busy=0. Reset aborts a running operation.
- Forwarding, per operand, applied to both rs and rt:
  - Source 1 (priority): the EX/MEM register, when ex_valid && ex_wreg && !ex_mem2reg && ex_waddr==addr && addr!=0.
  - Source 2: MEM/WB, when wb_wreg && wb_waddr==addr && addr!=0.
  - Otherwise: id data. Address 0 is never forwarded.
  - Load-use hazards are the ID hazard unit's job.
- Operand B = id_imm when id_aluimm, else the forwarded rt.
- Destination address = rt when id_regrt, else rd.
- ALU is combinational: ADD, SUB, AND, OR, XOR, NOR, SLT, SLTU, SLL, SRL, SRA, LUI.
  - Shift amount is B[log2(DW)-1:0], shifting A.
  - ADD/SUB wrap modulo 2^DW; no overflow trap.
- Result select: MFHI→HI, MFLO→LO, else the ALU result.
- ex_stall = id_valid && !flush && md_busy && id_md_op∈{1..6}.
- EX/MEM update each cycle:
  - If ex_stall or flush or !id_valid, load a bubble (ex_valid=0, ex_wreg=ex_wmem=ex_mem2reg=0; data fields don't-care, held).
  - Else latch result, forwarded rt, destination and controls, with ex_valid=1.
- Multiply/divide unit:
  - Accepts an operation when id_valid && !flush && !ex_stall && id_md_op∈{1..4}.
  - Operands are latched after forwarding.
  - md_busy rises the next cycle and stays high exactly DW cycles.
  - HI/LO are written on the last busy cycle; md_busy falls the next cycle, at which point HI/LO are visible.
  - The accepting instruction retires normally (ex_valid=1, ex_wreg=0), with no stall on acceptance.
  - MULT/MULTU: radix-2 shift-add on magnitudes; the signed result is negated when signs differ; {HI,LO} = 2·DW-bit product.
  - DIV/DIVU: restoring division; LO=quotient, HI=remainder.
    - Signed: quotient truncates toward zero; remainder takes the dividend's sign.
    - Divide by zero: LO = all ones, HI = dividend; runs the full DW cycles.
  - Flush does not abort a running operation. A second operation waits via ex_stall.
- A flush arriving together with a stall: flush wins; bubble, and ex_stall=0.

Decomposition:
- Package ex_pkg:
  - ALU op localparams (ADD=0 … LUI=11).
  - md_op localparams.
  - Forwarding select enum (FWD_ID, FWD_EXMEM, FWD_MEMWB).
- One sub-module, md_unit: start, op, a, b → busy, hi, lo. Contains the counter and the shift-add and restoring-division datapath.
- ALU and forwarding muxes stay inline.

Test Plan:
- Back-to-back dependency: ADD r3=5+7, then SUB r4=r3−2 issued the next cycle → ex_alu_out=12 then 10, with rs taken from EX/MEM.
- MEM/WB forwarding and r0: wb writes r3=0x55 while EX/MEM also targets r3=0x99 → r3 operand =0x99. An instruction targeting r0 with rs=r0 → operand equals id_rs_data (0).
- MULT −3×7 (DW=32), then MFLO issued the next cycle:
  - ex_stall high for 32 cycles.
  - ex_valid=0 during the stall.
  - MFLO then yields 0xFFFFFFEB; MFHI yields 0xFFFFFFFF.
- DIV −7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/0 → LO=0xFFFFFFFF, HI=7.
- Flush during a stalled MFHI → ex_stall=0 and a bubble. The running MULT still completes and HI is updated.
- Reset asserted at iteration 10 of a DIV → md_busy=0 and HI=LO=0 next cycle; a following MFLO returns 0 with no stall.
